// File: rtl/mem_test_master.sv
// mem_test_master: write-then-readback memory self-test initiator on a valid/ready handshake.
// Fills 0..DEPTH-1 with SEED^addr, reads it back and reports mismatches and handshake timeouts.
module mem_test_master #(
    parameter int              WIDTH      = 16,
    parameter int              DEPTH      = 64,
    parameter int              ADDR_WIDTH = 16,
    parameter logic [15:0]     SEED       = 16'hA5A5,
    parameter int              CNT_WIDTH  = 8,
    parameter int              TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [CNT_WIDTH-1:0]  err_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      wdata_o,
    input  logic [WIDTH-1:0]      rdata_i,
    output logic                  wr_rd_o,
    output logic                  valid_o,
    input  logic                  ready_i
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE} state_t;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [TW-1:0] WAIT_MAX = TW'(TIMEOUT - 1);

    function automatic logic [WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] x);
        return WIDTH'(SEED) ^ WIDTH'(x);
    endfunction

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] a_n, first_n;
    logic [TW-1:0]         wcnt, wcnt_n;
    logic [CNT_WIDTH-1:0]  err_n;
    logic                  to_n, valid_n, wr_n, busy_n, done_n;
    logic [WIDTH-1:0]      wdata_n;

    always_comb begin
        state_n = state;
        a_n     = addr_o;
        err_n   = err_count_o;
        first_n = first_err_addr_o;
        to_n    = timeout_o;
        case (state)
            IDLE, DONE: if (start_i) begin
                state_n = WR_REQ;
                a_n     = '0;
                err_n   = '0;
                first_n = '0;
                to_n    = 1'b0;
            end
            WR_REQ: if (ready_i) state_n = WR_GAP;
            WR_GAP: if (!ready_i) begin
                state_n = addr_o == LAST ? RD_REQ : WR_REQ;
                a_n     = addr_o == LAST ? '0 : addr_o + 1'b1;
            end
            RD_REQ: if (ready_i) begin
                state_n = RD_GAP;
                if (rdata_i != pattern(addr_o)) begin
                    err_n   = &err_count_o ? err_count_o : err_count_o + 1'b1;
                    first_n = err_count_o == '0 ? addr_o : first_err_addr_o;
                end
            end
            RD_GAP: if (!ready_i) begin
                state_n = addr_o == LAST ? DONE : RD_REQ;
                a_n     = addr_o == LAST ? addr_o : addr_o + 1'b1;
            end
            default: state_n = IDLE;
        endcase
        // a stalled handshake state gives up after TIMEOUT edges without progress
        if (state inside {WR_REQ, WR_GAP, RD_REQ, RD_GAP} && state_n == state && wcnt == WAIT_MAX) begin
            state_n = DONE;
            to_n    = 1'b1;
        end
        wcnt_n  = state_n != state ? '0 : wcnt + 1'b1;
        valid_n = state_n == WR_REQ || state_n == RD_REQ;
        wr_n    = state_n == WR_REQ ? 1'b1 : state_n == RD_REQ ? 1'b0 : wr_rd_o;
        wdata_n = state_n == WR_REQ ? pattern(a_n) : wdata_o;
        busy_n  = state_n inside {WR_REQ, WR_GAP, RD_REQ, RD_GAP};
        done_n  = state_n == DONE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= IDLE;
            wcnt             <= '0;
            addr_o           <= '0;
            err_count_o      <= '0;
            first_err_addr_o <= '0;
            timeout_o        <= 1'b0;
            valid_o          <= 1'b0;
            wr_rd_o          <= 1'b0;
            wdata_o          <= '0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            pass_o           <= 1'b0;
        end else begin
            state            <= state_n;
            wcnt             <= wcnt_n;
            addr_o           <= a_n;
            err_count_o      <= err_n;
            first_err_addr_o <= first_n;
            timeout_o        <= to_n;
            valid_o          <= valid_n;
            wr_rd_o          <= wr_n;
            wdata_o          <= wdata_n;
            busy_o           <= busy_n;
            done_o           <= done_n;
            pass_o           <= done_n && err_n == '0 && !to_n;
        end
    end
endmodule

// File: tb/tb_mem_test_master.sv
// tb_mem_test_master: directed/randomized bench with a behavioural single-port memory and result model.
module tb_mem_test_master;
    logic        clk_i = 0, rst_i = 1, start_i = 0, ready_m = 0;
    logic        busy_o, done_o, pass_o, timeout_o, wr_rd_o, valid_o;
    logic [7:0]  err_count_o;
    logic [15:0] first_err_addr_o, addr_o, wdata_o, rdata_m;
    logic [15:0] mem [64];
    logic        corrupt [64];
    logic        tie0 = 0;
    logic [15:0] w5;
    int tests = 0, fails = 0;

    mem_test_master dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .pass_o(pass_o), .timeout_o(timeout_o), .err_count_o(err_count_o),
        .first_err_addr_o(first_err_addr_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .rdata_i(rdata_m), .wr_rd_o(wr_rd_o), .valid_o(valid_o), .ready_i(ready_m)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] pat(input int a);
        return 16'hA5A5 ^ a[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // memory: ready follows valid by one cycle, read data registered alongside it
    always @(posedge clk_i) begin
        ready_m <= tie0 ? 1'b0 : valid_o;
        if (valid_o && wr_rd_o) begin
            chk("wdata_vs_addr", wdata_o, pat(int'(addr_o)));
            mem[addr_o[5:0]] <= wdata_o;
            if (addr_o == 16'd5) w5 <= wdata_o;
        end
        if (valid_o && !wr_rd_o) rdata_m <= mem[addr_o[5:0]] ^ {15'b0, corrupt[addr_o[5:0]]};
    end

    task automatic start_test();
        start_i = 1;
        tick();
        start_i = 0;
        chk("busy_after_start", busy_o, 1);
        chk("done_clear_at_start", done_o, 0);
        chk("err_clear_at_start", err_count_o, 0);
    endtask

    task automatic wait_done(input int budget, input int pulse_at, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            start_i = (i == pulse_at);
            tick();
            if (done_o) begin
                lat = i;
                break;
            end
        end
        start_i = 0;
    endtask

    task automatic full_run(input string tag, input int pulse_at);
        int lat, exp_err, exp_first, bad;
        exp_err = 0;
        exp_first = 0;
        for (int a = 63; a >= 0; a--) if (corrupt[a]) begin
            exp_err++;
            exp_first = a;
        end
        w5 = 16'h0;
        start_test();
        wait_done(700, pulse_at, lat);
        chk({tag, "_latency"}, lat, 512);
        chk({tag, "_pass"}, pass_o, exp_err == 0);
        chk({tag, "_err_count"}, err_count_o, exp_err);
        chk({tag, "_first_err"}, first_err_addr_o, exp_first);
        chk({tag, "_busy_at_done"}, busy_o, 0);
        chk({tag, "_timeout"}, timeout_o, 0);
        chk({tag, "_valid_at_done"}, valid_o, 0);
        chk({tag, "_wdata_addr5"}, w5, 16'hA5A0);
        bad = 0;
        for (int a = 0; a < 64; a++) if (mem[a] !== pat(a)) bad++;
        chk({tag, "_mem_image"}, bad, 0);
        repeat ($urandom_range(1, 6)) tick();
        chk({tag, "_done_held"}, done_o, 1);
    endtask

    initial begin
        int lat, found;
        for (int a = 0; a < 64; a++) begin
            mem[a] = 16'($urandom);
            corrupt[a] = 0;
        end
        repeat (3) tick();
        chk("reset_valid", valid_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        rst_i = 0;
        repeat ($urandom_range(1, 8)) tick();
        chk("idle_done", done_o, 0);

        full_run("clean_midpulse", 100 + $urandom_range(0, 150));

        corrupt[10] = 1;
        corrupt[20] = 1;
        full_run("flip10_20", 0);
        for (int a = 0; a < 64; a++) corrupt[a] = 0;
        full_run("restart_from_done", 0);

        repeat ($urandom_range(1, 4)) corrupt[$urandom_range(0, 63)] = 1;
        full_run("random_flips", 300 + $urandom_range(0, 100));
        for (int a = 0; a < 64; a++) corrupt[a] = 0;

        tie0 = 1;
        repeat (2) tick();
        start_test();
        chk("to_wr_addr0", addr_o, 0);
        wait_done(100, 0, lat);
        chk("to_latency", lat, 16);
        chk("to_flag", timeout_o, 1);
        chk("to_pass", pass_o, 0);
        chk("to_valid", valid_o, 0);
        chk("to_busy", busy_o, 0);
        tie0 = 0;
        repeat (2) tick();
        full_run("after_timeout", 0);

        corrupt[7] = 1;
        found = 0;
        start_i = 1;
        tick();
        start_i = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            tick();
            found = int'(valid_o && !wr_rd_o && addr_o == 16'd30);
        end
        chk("reach_rd30", found, 1);
        #2 rst_i = 1;
        #1;
        chk("arst_valid", valid_o, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_addr", addr_o, 0);
        chk("arst_err", err_count_o, 0);
        chk("arst_first", first_err_addr_o, 0);
        chk("arst_wdata", wdata_o, 0);
        chk("arst_wr_rd", wr_rd_o, 0);
        repeat (3) tick();
        rst_i = 0;
        corrupt[7] = 0;
        tick();
        full_run("after_reset", 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_test_master.md
Name: mem_test_master

Overview:
- Initiator (requester) side of the single-port memory valid/ready handshake.
- Fills addresses 0..DEPTH-1 with a seeded pattern, then reads every address back and compares it against the expected value.
- Reports done, pass, mismatch count, first failing address and a handshake timeout flag.
- Sits between a test/control sequencer and the memory block. Used as power-on self-test and as a traffic generator for verification.

Parameters:
- WIDTH, 16, data width; must match the memory.
- DEPTH, 64, number of addresses tested (0..DEPTH-1); DEPTH <= 2^ADDR_WIDTH.
- ADDR_WIDTH, 16, address bus width.
- SEED, 16'hA5A5, pattern seed.
- CNT_WIDTH, 8, width of the error counter.
- TIMEOUT, 16, maximum cycles spent waiting on ready_i in any one state.

Ports:
- clk_i  input  1  clock; rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- start_i  input  1  begin test; sampled only in IDLE or DONE.
- busy_o  output  1  high from the first request through the last transfer.
- done_o  output  1  high in DONE; held until restart or reset.
- pass_o  output  1  done_o & err_count_o==0 & ~timeout_o.
- timeout_o  output  1  a wait exceeded TIMEOUT cycles.
- err_count_o  output  CNT_WIDTH  read mismatches; saturating.
- first_err_addr_o  output  ADDR_WIDTH  address of the first mismatch.
- addr_o  output  ADDR_WIDTH  memory address.
- wdata_o  output  WIDTH  memory write data.
- rdata_i  input  WIDTH  memory read data.
- wr_rd_o  output  1  1 = write, 0 = read.
- valid_o  output  1  request valid.
- ready_i  input  1  memory acknowledge.

Behaviour:
- Reset: all outputs and registers go to 0 immediately (asynchronous), FSM goes to IDLE.
  - Reset mid-operation aborts the test without a clock edge.
  - Memory contents are not restored.
- Pattern: exp(a) = SEED ^ a. The address is zero-extended or truncated to WIDTH.
- All outputs are registered.
- FSM states: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE.
- IDLE / DONE:
  - start_i=1 clears err_count_o, first_err_addr_o, timeout_o and the address counter.
  - Then go to WR_REQ; busy_o=1, done_o=0.
  - start_i in any other state is ignored.
- WR_REQ: valid_o=1, wr_rd_o=1, addr_o=a, wdata_o=exp(a).
  - On an edge with ready_i=1: go to WR_GAP and drop valid_o.
- WR_GAP: valid_o=0. Wait for ready_i sampled 0.
  - Then, if a==DEPTH-1: set a=0, go to RD_REQ.
  - Otherwise a=a+1, go to WR_REQ.
  - The memory keeps ready high for one cycle after valid falls, so a new request is never issued while ready_i=1.
- RD_REQ: valid_o=1, wr_rd_o=0, addr_o=a.
  - On an edge with ready_i=1: capture rdata_i, compare it to exp(a), go to RD_GAP.
  - On mismatch: err_count_o increments (saturates at all-ones). If this is the first mismatch, first_err_addr_o=a.
- RD_GAP: as WR_GAP, except the last address goes to DONE (busy_o=0, done_o=1).
- Timing against the standard memory:
  - 4 cycles per transfer (request, ack, gap, ready-low).
  - start_i sampled at edge s gives done_o=1 after edge s+8*DEPTH (512 for DEPTH=64).
- Timeout: a per-state wait counter resets on each state entry.
  - If it reaches TIMEOUT in any REQ or GAP state: timeout_o=1, valid_o=0, go to DONE.
  - pass_o=0 in this case.
- wdata_o holds its last value during reads.
- Duplicate requests: the memory re-executes the access on the cycle valid_o falls. This is benign for both writes and reads, and is not counted as an extra transfer.

Test Plan:
- Async reset asserted mid-clock -> all outputs 0 before the next edge; valid_o=0.
- start_i pulse, bench memory model (DEPTH=64) -> write at addr 5 carries wdata_o=16'hA5A0. done_o rises 512 cycles after start; pass_o=1, err_count_o=0, busy_o low at done.
- Model flips bit 0 of read data at addr 10 and 20 -> err_count_o=2, first_err_addr_o=10, pass_o=0.
- ready_i tied 0 -> after 16 cycles in WR_REQ at addr 0: timeout_o=1, done_o=1, pass_o=0, valid_o=0.
- start_i pulsed mid-write phase -> ignored, completion cycle unchanged. start_i in DONE after a failing run -> counters clear, second clean run gives pass_o=1.
- rst_i asserted during the read phase at addr 30, then released and started again -> full clean run; first_err_addr_o=0, err_count_o=0.
